// File: rtl/sync_queue.sv
`default_nettype none
// ============================================================================
// Module   : sync_queue
// Brief    : Synchronous FIFO/LIFO buffer with push/pop handshake, status
//            flags and sticky errors. Optional almost-full/almost-empty
//            outputs enabled by defining SYNC_QUEUE_ALMOST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sync_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int MODE  = 0
`ifdef SYNC_QUEUE_ALMOST_EN
    ,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 1
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
`ifdef SYNC_QUEUE_ALMOST_EN
    ,
    output logic                       o_almost_full,
    output logic                       o_almost_empty
`endif
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_full;
    logic               r_empty;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_ptr_w-1:0] w_wr_addr;
    logic [c_ptr_w-1:0] w_rd_addr;

    // A push into a full buffer is only legal when a pop frees a slot this cycle.
    assign w_pop_ok  = i_pop && !r_empty;
    assign w_push_ok = i_push && (!r_full || w_pop_ok);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    generate
        if (MODE == 0) begin : g_fifo
            localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else if (i_clear) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push_ok)
                        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
                    if (w_pop_ok)
                        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
                end
            end

            assign w_wr_addr = r_wr_ptr;
            assign w_rd_addr = r_rd_ptr;
        end else begin : g_lifo
            // Stack pointer is the occupancy itself; the top entry lives at sp-1.
            logic [c_ptr_w-1:0] w_sp;
            logic [c_ptr_w-1:0] w_top;

            assign w_sp      = r_count[c_ptr_w-1:0];
            assign w_top     = w_sp - c_ptr_w'(1);
            assign w_rd_addr = w_top;
            assign w_wr_addr = w_pop_ok ? w_top : w_sp;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_clear)
            r_mem[w_wr_addr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clear) begin
            r_valid     <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= w_pop_ok;
            if (w_pop_ok)
                r_data <= r_mem[w_rd_addr];
            if (i_push && !w_push_ok)
                r_overflow <= 1'b1;
            if (i_pop && !w_pop_ok)
                r_underflow <= 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

`ifdef SYNC_QUEUE_ALMOST_EN
    localparam logic [c_cnt_w-1:0] c_afull  = c_cnt_w'(AFULL_LVL);
    localparam logic [c_cnt_w-1:0] c_aempty = c_cnt_w'(AEMPTY_LVL);
    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else if (i_clear) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= c_afull);
            r_almost_empty <= (w_count_nxt <= c_aempty);
        end
    end

    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
`endif

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_queue
// Brief    : Scoreboard bench for sync_queue: FIFO depth 4, FIFO depth 3 and
//            LIFO depth 4 instances driven against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push [3];
    logic       pop  [3];
    logic       clr  [3];
    logic [7:0] din  [3];
    logic [7:0] odata[3];
    logic       ovld [3];
    logic       ofull[3];
    logic       oemp [3];
    logic       oovf [3];
    logic       ounf [3];
    logic       oaf  [3];
    logic       oae  [3];
    logic [2:0] cnt0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;

    int n_chk = 0;
    int n_bad = 0;

    // behavioural model: index 0 oldest, index cnt-1 newest
    int         dep [3] = '{4, 3, 4};
    int         mode[3] = '{0, 0, 1};
    int         mc  [3];
    logic [7:0] mm  [3][4];
    logic [7:0] mlast[3];
    bit         movf[3];
    bit         munf[3];
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sync_queue #(.WIDTH(8), .DEPTH(4), .MODE(0)) u_fifo4 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr[0]), .i_push(push[0]), .i_pop(pop[0]),
        .i_data(din[0]), .o_data(odata[0]), .o_valid(ovld[0]), .o_full(ofull[0]),
        .o_empty(oemp[0]), .o_count(cnt0), .o_overflow(oovf[0]), .o_underflow(ounf[0])
`ifdef SYNC_QUEUE_ALMOST_EN
        , .o_almost_full(oaf[0]), .o_almost_empty(oae[0])
`endif
    );

    sync_queue #(.WIDTH(8), .DEPTH(3), .MODE(0)) u_fifo3 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr[1]), .i_push(push[1]), .i_pop(pop[1]),
        .i_data(din[1]), .o_data(odata[1]), .o_valid(ovld[1]), .o_full(ofull[1]),
        .o_empty(oemp[1]), .o_count(cnt1), .o_overflow(oovf[1]), .o_underflow(ounf[1])
`ifdef SYNC_QUEUE_ALMOST_EN
        , .o_almost_full(oaf[1]), .o_almost_empty(oae[1])
`endif
    );

    sync_queue #(.WIDTH(8), .DEPTH(4), .MODE(1)) u_lifo4 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr[2]), .i_push(push[2]), .i_pop(pop[2]),
        .i_data(din[2]), .o_data(odata[2]), .o_valid(ovld[2]), .o_full(ofull[2]),
        .o_empty(oemp[2]), .o_count(cnt2), .o_overflow(oovf[2]), .o_underflow(ounf[2])
`ifdef SYNC_QUEUE_ALMOST_EN
        , .o_almost_full(oaf[2]), .o_almost_empty(oae[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] get_cnt(input int u);
        case (u)
            0:       return cnt0;
            1:       return {1'b0, cnt1};
            default: return cnt2;
        endcase
    endfunction

    task automatic check_state(input int u);
        check($sformatf("u%0d count", u), 32'(get_cnt(u)), 32'(mc[u]));
        check($sformatf("u%0d full", u), 32'(ofull[u]), 32'(mc[u] == dep[u]));
        check($sformatf("u%0d empty", u), 32'(oemp[u]), 32'(mc[u] == 0));
        check($sformatf("u%0d overflow", u), 32'(oovf[u]), 32'(movf[u]));
        check($sformatf("u%0d underflow", u), 32'(ounf[u]), 32'(munf[u]));
`ifdef SYNC_QUEUE_ALMOST_EN
        check($sformatf("u%0d afull", u), 32'(oaf[u]), 32'(mc[u] >= dep[u] - 2));
        check($sformatf("u%0d aempty", u), 32'(oae[u]), 32'(mc[u] <= 1));
`endif
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            mc[u] = 0; mlast[u] = 8'h00; movf[u] = 1'b0; munf[u] = 1'b0;
        end
    endtask

    // One cycle of stimulus on unit u, then compare the result.
    task automatic op(input int u, input bit ps, input bit pp, input logic [7:0] d);
        bit         pop_ok;
        bit         push_ok;
        logic [7:0] e;
        pop_ok  = pp && (mc[u] > 0);
        push_ok = ps && ((mc[u] < dep[u]) || pop_ok);
        if (pop_ok) begin
            e = (mode[u] == 0) ? mm[u][0] : mm[u][mc[u]-1];
            sb.push_back(e);
            mlast[u] = e;
            if (mode[u] == 0)
                for (int i = 0; i < 3; i++) mm[u][i] = mm[u][i+1];
            mc[u]--;
        end
        if (push_ok) begin
            mm[u][mc[u]] = d;
            mc[u]++;
        end
        if (ps && !push_ok) movf[u] = 1'b1;
        if (pp && !pop_ok)  munf[u] = 1'b1;

        @(negedge clk);
        push[u] = ps; pop[u] = pp; din[u] = d;
        @(posedge clk);
        #1;
        push[u] = 1'b0; pop[u] = 1'b0;
        check($sformatf("u%0d valid", u), 32'(ovld[u]), 32'(pop_ok));
        if (ovld[u]) begin
            e = (sb.size() > 0) ? sb.pop_front() : ~odata[u];
            check($sformatf("u%0d pop data", u), 32'(odata[u]), 32'(e));
        end else begin
            check($sformatf("u%0d held data", u), 32'(odata[u]), 32'(mlast[u]));
        end
        check_state(u);
    endtask

    task automatic do_clear(input int u);
        @(negedge clk);
        clr[u] = 1'b1; push[u] = 1'b1; pop[u] = 1'b1; din[u] = 8'hEE;
        @(posedge clk);
        #1;
        clr[u] = 1'b0; push[u] = 1'b0; pop[u] = 1'b0;
        mc[u] = 0; movf[u] = 1'b0; munf[u] = 1'b0;
        check($sformatf("u%0d clr valid", u), 32'(ovld[u]), 32'd0);
        check($sformatf("u%0d clr data held", u), 32'(odata[u]), 32'(mlast[u]));
        check_state(u);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            push[u] = 1'b0; pop[u] = 1'b0; clr[u] = 1'b0; din[u] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d rst data", u), 32'(odata[u]), 32'd0);
            check($sformatf("u%0d rst valid", u), 32'(ovld[u]), 32'd0);
            check_state(u);
        end
        @(negedge clk);
        rst = 1'b0;

        // FIFO depth 4: fill, overflow, drain
        op(0, 1, 0, 8'h11); op(0, 1, 0, 8'h22); op(0, 1, 0, 8'h33); op(0, 1, 0, 8'h44);
        op(0, 1, 0, 8'h55);
        for (int i = 0; i < 4; i++) op(0, 0, 1, 8'h00);
        do_clear(0);

        // FIFO depth 3: steady alternation across pointer wrap
        for (int i = 0; i < 10; i++) begin
            op(1, 1, 0, 8'(8'hA0 + i));
            op(1, 0, 1, 8'h00);
        end

        // FIFO full with simultaneous push/pop
        for (int i = 1; i <= 4; i++) op(0, 1, 0, 8'(i));
        op(0, 1, 1, 8'hAA);
        for (int i = 0; i < 4; i++) op(0, 0, 1, 8'h00);

        // LIFO: push/pop replace top, drain, underflow
        op(2, 1, 0, 8'h01); op(2, 1, 0, 8'h02); op(2, 1, 0, 8'h03);
        op(2, 1, 1, 8'h09);
        for (int i = 0; i < 3; i++) op(2, 0, 1, 8'h00);
        op(2, 0, 1, 8'h00);

        // push+pop while empty, both modes
        op(0, 1, 1, 8'h5A); op(0, 0, 1, 8'h00);
        op(2, 1, 1, 8'h5A); op(2, 0, 1, 8'h00);

        // LIFO fill to full and random-ish mix
        for (int i = 0; i < 12; i++)
            op(2, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0), 8'($urandom));

        // asynchronous reset between edges
        op(0, 1, 0, 8'h61); op(0, 1, 0, 8'h62);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d async rst data", u), 32'(odata[u]), 32'd0);
            check($sformatf("u%0d async rst valid", u), 32'(ovld[u]), 32'd0);
            check_state(u);
        end
        @(negedge clk);
        push[0] = 1'b1; din[0] = 8'h99;
        @(posedge clk);
        @(negedge clk);
        push[0] = 1'b0;
        rst = 1'b0;
        op(0, 1, 0, 8'h77); op(0, 0, 1, 8'h00);

        // synchronous clear with errors set and data held
        op(2, 1, 0, 8'h31); op(2, 1, 0, 8'h32); op(2, 0, 1, 8'h00);
        op(2, 0, 1, 8'h00); op(2, 0, 1, 8'h00);
        do_clear(2);
        op(2, 1, 0, 8'h77); op(2, 0, 1, 8'h00);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
